pes_usr_burst: RTL and testbench
================================

// Module: pes_usr_burst
// PURPOSE
//   Parametrised universal shift register, successor to the 4-bit universal shift register.
//   Adds WIDTH generalisation, serial in/out ends, arithmetic shift, rotate and clear ops.
//   Adds an auto-burst sequencer that performs N back-to-back shifts under a start/busy/done handshake.
//   Serves as the serialiser/deserialiser and bit-manipulation register in the datapath.
// PARAMETERS
//   WIDTH    8  register width in bits (>=2)
//   BURST_W  4  width of burst_len; maximum burst = 2**BURST_W-1 shifts
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-high reset
//   mode       in   3        op select (see BEHAVIOUR)
//   din        in   WIDTH    parallel load data
//   sin_msb    in   1        serial in, enters at bit WIDTH-1 on logical shift-right
//   sin_lsb    in   1        serial in, enters at bit 0 on shift-left
//   start      in   1        request a burst of the shift/rotate op currently on mode
//   burst_len  in   BURST_W  number of shifts in the burst
//   q          out  WIDTH    register contents
//   sout_lsb   out  1        q[0]
//   sout_msb   out  1        q[WIDTH-1]
//   busy       out  1        burst in progress
//   done       out  1        one-cycle pulse after a burst completes
// BEHAVIOUR
//   Reset (async, any time incl. mid-burst):
//     - q=0, busy=0, done=0; FSM goes to IDLE; counter cleared; no done pulse issued.
//   mode encoding (all ops are registered, 1-cycle latency):
//     000 hold
//     001 SHR  q<={sin_msb,q[W-1:1]}
//     010 SHL  q<={q[W-2:0],sin_lsb}
//     011 LOAD q<=din
//     100 ROR  q<={q[0],q[W-1:1]}
//     101 ROL  q<={q[W-2:0],q[W-1]}
//     110 ASR  q<={q[W-1],q[W-1:1]}
//     111 CLR  q<=0
//   Compatibility: with sin_*=0 and WIDTH=4, codes 000-011 match the 4-bit register exactly.
//   FSM states IDLE, RUN, DONE.
//   IDLE:
//     - Applies mode every cycle (single-step).
//     - start=1 with a shift/rotate op (001,010,100,101,110) and burst_len>0:
//       latch op and burst_len, no shift this cycle, go to RUN.
//     - start=1 with a shift/rotate op and burst_len==0: no shift, go to DONE.
//     - start=1 with hold/load/clear: start is ignored; the op executes as a single step.
//   RUN:
//     - busy=1; each cycle applies the latched op and decrements the counter.
//     - mode, din and start are ignored; sin_msb/sin_lsb are sampled live on each shift cycle.
//     - After the shift where the counter reaches 0, go to DONE.
//   DONE: done=1 for exactly one cycle, busy=0, q held, mode ignored; then IDLE.
//   Outputs: busy/done are decoded from registered state (no combinational path from inputs).
//   sout_* are taken directly from q.
// CONFIGURATION
//   PES_USR_ROTATE_EN
//     - defined: ROR/ROL operate as listed and are accepted for bursts.
//     - undefined: codes 100/101 act as hold, and start with them is ignored.
//   All other ops are unaffected by the macro.
// STRUCTURE
//   pes_usr_pkg holds:
//     - typedef enum logic[2:0] usr_op_e (OP_HOLD..OP_CLR);
//     - typedef enum usr_state_e {ST_IDLE,ST_RUN,ST_DONE};
//     - function is_shift_op(usr_op_e).
//   Sub-module pes_usr_step: purely combinational next-q function (op, q, sin_msb, sin_lsb) -> q_next.
//   The top level contains the FSM, the counter and the q register.
// TESTING
//   1. rst=1 mid-operation -> q=0, busy=0, done=0 immediately, before any clock edge.
//   2. W=8: LOAD din=8'hA5 -> q=A5; SHR, sin_msb=0 -> 52; SHL, sin_lsb=1 -> A5.
//   3. q=8'h90, ASR -> C8; CLR -> 00; hold for 3 cycles -> q unchanged.
//   4. ROL burst (macro on): q=8'h81, start, burst_len=3
//      -> busy=1 for 3 cycles, q=0C, done pulses 1 cycle; mode toggled during busy has no effect.
//   5. start, SHR, burst_len=0 -> busy never asserted, done=1 next cycle, q unchanged.
//   6. Burst of 5 with rst pulsed after 2 shifts -> q=0, IDLE, no done.
//      Macro off: mode=100 -> q unchanged.

Source files
------------

// File: rtl/pes_usr_pkg.sv
// Shared op codes, FSM states and op classification for the universal burst shift register.
// PES_USR_ROTATE_EN enables ROR/ROL; without it they behave as hold and cannot start a burst.
package pes_usr_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } usr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } usr_state_e;

  // Ops that move bits and are therefore eligible for an auto-burst.
  function automatic logic is_shift_op(usr_op_e op);
    logic r;
    r = 1'b0;
    case (op)
      OP_SHR, OP_SHL, OP_ASR: r = 1'b1;
`ifdef PES_USR_ROTATE_EN
      OP_ROR, OP_ROL:         r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pes_usr_burst_if.sv
// Bus bundle between the controller and the universal burst shift register.
interface pes_usr_burst_if #(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
);
  logic [2:0]         mode;
  logic [WIDTH-1:0]   din;
  logic               sin_msb;
  logic               sin_lsb;
  logic               start;
  logic [BURST_W-1:0] burst_len;
  logic [WIDTH-1:0]   q;
  logic               sout_lsb;
  logic               sout_msb;
  logic               busy;
  logic               done;

  modport master (
    output mode, din, sin_msb, sin_lsb, start, burst_len,
    input  q, sout_lsb, sout_msb, busy, done
  );

  modport slave (
    input  mode, din, sin_msb, sin_lsb, start, burst_len,
    output q, sout_lsb, sout_msb, busy, done
  );
endinterface

// File: rtl/pes_usr_step.sv
// Combinational next-value function of the shift register for one op.
// PES_USR_ROTATE_EN selects whether ROR/ROL rotate or hold.
module pes_usr_step
  import pes_usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  usr_op_e          op,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      OP_SHR:  q_next = {sin_msb, q[WIDTH-1:1]};
      OP_SHL:  q_next = {q[WIDTH-2:0], sin_lsb};
      OP_LOAD: q_next = din;
`ifdef PES_USR_ROTATE_EN
      OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
      OP_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLR:  q_next = '0;
      default: q_next = q;
    endcase
  end

endmodule

// File: rtl/pes_usr_burst.sv
// Universal shift register with an auto-burst sequencer (start/busy/done handshake).
// PES_USR_ROTATE_EN enables ROR/ROL single steps and bursts.
module pes_usr_burst
  import pes_usr_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int BURST_W = 4
) (
  input logic            clk,
  input logic            rst,
  pes_usr_burst_if.slave bus
);

  localparam logic [BURST_W-1:0] CNT_ONE = BURST_W'(1);

  usr_state_e         state, state_n;
  usr_op_e            op_r, op_n, step_op, mode_op;
  logic [BURST_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0]   q_r, q_next;

  assign mode_op = usr_op_e'(bus.mode);

  pes_usr_step #(.WIDTH(WIDTH)) u_step (
    .op      (step_op),
    .q       (q_r),
    .din     (bus.din),
    .sin_msb (bus.sin_msb),
    .sin_lsb (bus.sin_lsb),
    .q_next  (q_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_r  <= OP_HOLD;
      cnt   <= '0;
      q_r   <= '0;
    end else begin
      state <= state_n;
      op_r  <= op_n;
      cnt   <= cnt_n;
      q_r   <= q_next;
    end
  end

  // The start cycle only latches the burst; shifting begins in RUN.
  always_comb begin
    state_n = state;
    op_n    = op_r;
    cnt_n   = cnt;
    step_op = OP_HOLD;
    case (state)
      ST_IDLE: begin
        step_op = mode_op;
        if (bus.start && is_shift_op(mode_op)) begin
          step_op = OP_HOLD;
          if (bus.burst_len != '0) begin
            op_n    = mode_op;
            cnt_n   = bus.burst_len;
            state_n = ST_RUN;
          end else begin
            state_n = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        step_op = op_r;
        cnt_n   = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_n = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.q        = q_r;
  assign bus.sout_lsb = q_r[0];
  assign bus.sout_msb = q_r[WIDTH-1];
  assign bus.busy     = (state == ST_RUN);
  assign bus.done     = (state == ST_DONE);

endmodule

// File: tb/tb_pes_usr_burst.sv
// Self-checking bench for pes_usr_burst: directed scenarios plus random ops against a count-based model.
module tb_pes_usr_burst;

  localparam int WIDTH   = 8;
  localparam int BURST_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pes_usr_burst_if #(.WIDTH(WIDTH), .BURST_W(BURST_W)) bus ();

  pes_usr_burst #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: register value, shifts still owed by the burst, expected done flag.
  logic [WIDTH-1:0] mq;
  int               mrem;
  logic [2:0]       mop;
  logic             mdone;

  function automatic logic modelShift(input logic [2:0] m);
`ifdef PES_USR_ROTATE_EN
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
`else
    return (m == 3'd1) || (m == 3'd2) || (m == 3'd6);
`endif
  endfunction

  function automatic logic [WIDTH-1:0] modelOp(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] d, input logic sm, input logic sl);
    logic [WIDTH-1:0] msb;
    msb = {1'b1, {(WIDTH-1){1'b0}}};
    case (m)
      3'd1: return (v >> 1) | (sm ? msb : '0);
      3'd2: return (v << 1) | WIDTH'(sl);
      3'd3: return d;
`ifdef PES_USR_ROTATE_EN
      3'd4: return (v >> 1) | (v[0] ? msb : '0);
      3'd5: return (v << 1) | WIDTH'(v[WIDTH-1]);
`endif
      3'd6: return (v >> 1) | (v & msb);
      3'd7: return '0;
      default: return v;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, " q"},    32'(bus.q),        32'(mq));
    checkOutput({tag, " busy"}, 32'(bus.busy),     32'(mrem > 0));
    checkOutput({tag, " done"}, 32'(bus.done),     32'(mdone));
    checkOutput({tag, " sout"}, 32'({bus.sout_msb, bus.sout_lsb}), 32'({mq[WIDTH-1], mq[0]}));
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then compares.
  task automatic applyStimulus(input string tag, input logic [2:0] m, input logic [WIDTH-1:0] d,
                               input logic sm, input logic sl, input logic st,
                               input logic [BURST_W-1:0] len);
    bus.mode = m; bus.din = d; bus.sin_msb = sm; bus.sin_lsb = sl;
    bus.start = st; bus.burst_len = len;
    if (mrem > 0) begin
      mq = modelOp(mop, mq, d, sm, sl);
      mrem--;
      mdone = (mrem == 0);
    end else if (mdone) begin
      mdone = 1'b0;
    end else if (st && modelShift(m)) begin
      if (len != 0) begin
        mrem = int'(len);
        mop  = m;
      end else begin
        mdone = 1'b1;
      end
    end else begin
      mq = modelOp(m, mq, d, sm, sl);
    end
    @(posedge clk);
    #1;
    checkState(tag);
  endtask

  task automatic midCycleReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    mq = '0; mrem = 0; mdone = 1'b0;
    checkState(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 3'd0; bus.din = '0; bus.sin_msb = 1'b0; bus.sin_lsb = 1'b0;
    bus.start = 1'b0; bus.burst_len = '0;
    mq = '0; mrem = 0; mop = 3'd0; mdone = 1'b0;
    #1;
    checkState("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    applyStimulus("load A5", 3'd3, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("load A5 const", 32'(bus.q), 32'h A5);
    applyStimulus("shr", 3'd1, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("shr const", 32'(bus.q), 32'h52);
    applyStimulus("shl", 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    checkOutput("shl const", 32'(bus.q), 32'hA5);

    applyStimulus("load 90", 3'd3, 8'h90, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus("asr", 3'd6, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("asr const", 32'(bus.q), 32'hC8);
    applyStimulus("clr", 3'd7, 8'hFF, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("clr const", 32'(bus.q), 32'h00);
    applyStimulus("load 3C", 3'd3, 8'h3C, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus("hold", 3'd0, 8'hFF, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("hold const", 32'(bus.q), 32'h3C);

`ifdef PES_USR_ROTATE_EN
    applyStimulus("load 81", 3'd3, 8'h81, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus("rol start", 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3);
    checkOutput("rol start q", 32'(bus.q), 32'h81);
    for (int i = 0; i < 3; i++)
      applyStimulus("rol run", 3'($urandom_range(0, 7)), 8'($urandom), 1'b0, 1'b0, 1'b1, 4'd7);
    checkOutput("rol burst q", 32'(bus.q), 32'h0C);
    checkOutput("rol done", 32'(bus.done), 32'd1);
    applyStimulus("rol after", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
`else
    applyStimulus("ror off", 3'd4, 8'h00, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("ror off const", 32'(bus.q), 32'h3C);
    applyStimulus("rol off start", 3'd5, 8'h00, 1'b1, 1'b1, 1'b1, 4'd3);
    checkOutput("rol off busy", 32'(bus.busy), 32'd0);
`endif

    applyStimulus("len0 start", 3'd1, 8'h00, 1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("len0 done", 32'(bus.done), 32'd1);
    applyStimulus("len0 after", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);

    applyStimulus("load 0F", 3'd3, 8'h0F, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus("b5 start", 3'd2, 8'h00, 1'b0, 1'b1, 1'b1, 4'd5);
    applyStimulus("b5 run", 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus("b5 run", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("b5 two shifts", 32'(bus.q), 32'h3E);
    midCycleReset("b5 reset");
    applyStimulus("b5 after reset", 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 5)));
      if (i == 200) midCycleReset("random reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
